// File: rtl/dxp_serial_adder32_if.sv
// Handshake and operand/result bundle for the nibble-serial 32-bit add/subtract unit.
interface dxp_serial_adder32_if;
  logic        start;
  logic        sub;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        cout;
  logic        ovf;
  logic        zero;

  modport master (
    output start, sub, a, b,
    input  busy, done, result, cout, ovf, zero
  );

  modport slave (
    input  start, sub, a, b,
    output busy, done, result, cout, ovf, zero
  );
endinterface

// File: rtl/dxp_serial_adder32.sv
// Nibble-serial 32-bit add/subtract: one 4-bit slice adder, eight cycles per operation,
// least significant nibble first, with carry chained through a register between slices.

module dxp_4bitadder (
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic       carryin,
  output logic [3:0] s,
  output logic       carryout
);
  logic [3:0] p;
  logic [3:0] g;
  logic [4:0] c;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_pg
      assign p[gi] = x[gi] ^ y[gi];
      assign g[gi] = x[gi] & y[gi];
      assign s[gi] = p[gi] ^ c[gi];
    end
  endgenerate

  // Lookahead form: every carry is a function of p/g/carryin only.
  assign c[0] = carryin;
  assign c[1] = g[0] | (p[0] & carryin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & carryin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & carryin);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & carryin);
  assign carryout = c[4];
endmodule

module dxp_serial_adder32 (
  input logic                  clock,
  input logic                  resetn,
  dxp_serial_adder32_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t      state_reg, state_next;
  logic [31:0] opa_reg, opa_next;
  logic [31:0] opb_reg, opb_next;
  logic [31:0] acc_reg, acc_next;
  logic [31:0] result_reg, result_next;
  logic        c_reg, c_next;
  logic [2:0]  cnt_reg, cnt_next;
  logic        sa31_reg, sa31_next;
  logic        sb31_reg, sb31_next;
  logic        cout_reg, cout_next;
  logic        ovf_reg, ovf_next;
  logic        zero_reg, zero_next;

  logic [3:0]  slice_s;
  logic        slice_co;
  logic [31:0] acc_shift;
  logic        accept;

  dxp_4bitadder u_slice (
    .x        (opa_reg[3:0]),
    .y        (opb_reg[3:0]),
    .carryin  (c_reg),
    .s        (slice_s),
    .carryout (slice_co)
  );

  assign acc_shift = {slice_s, acc_reg[31:4]};
  // A new request is taken when idle or in the done cycle (back-to-back).
  assign accept    = bus.start && ((state_reg == IDLE) || (state_reg == FIN));

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_reg  <= IDLE;
      opa_reg    <= '0;
      opb_reg    <= '0;
      acc_reg    <= '0;
      result_reg <= '0;
      c_reg      <= 1'b0;
      cnt_reg    <= '0;
      sa31_reg   <= 1'b0;
      sb31_reg   <= 1'b0;
      cout_reg   <= 1'b0;
      ovf_reg    <= 1'b0;
      zero_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      opa_reg    <= opa_next;
      opb_reg    <= opb_next;
      acc_reg    <= acc_next;
      result_reg <= result_next;
      c_reg      <= c_next;
      cnt_reg    <= cnt_next;
      sa31_reg   <= sa31_next;
      sb31_reg   <= sb31_next;
      cout_reg   <= cout_next;
      ovf_reg    <= ovf_next;
      zero_reg   <= zero_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    opa_next    = opa_reg;
    opb_next    = opb_reg;
    acc_next    = acc_reg;
    result_next = result_reg;
    c_next      = c_reg;
    cnt_next    = cnt_reg;
    sa31_next   = sa31_reg;
    sb31_next   = sb31_reg;
    cout_next   = cout_reg;
    ovf_next    = ovf_reg;
    zero_next   = zero_reg;

    case (state_reg)
      IDLE: begin
        if (bus.start) state_next = RUN;
      end
      RUN: begin
        acc_next = acc_shift;
        opa_next = {4'b0000, opa_reg[31:4]};
        opb_next = {4'b0000, opb_reg[31:4]};
        c_next   = slice_co;
        cnt_next = cnt_reg + 3'd1;
        // Final nibble: publish from the freshly completed sum so flags land on this edge.
        if (cnt_reg == 3'd7) begin
          state_next  = FIN;
          result_next = acc_shift;
          cout_next   = slice_co;
          zero_next   = (acc_shift == 32'd0);
          ovf_next    = (sa31_reg == sb31_reg) && (acc_shift[31] != sa31_reg);
        end
      end
      FIN: begin
        state_next = bus.start ? RUN : IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    if (accept) begin
      opa_next  = bus.a;
      opb_next  = bus.b ^ {32{bus.sub}};
      c_next    = bus.sub;
      cnt_next  = 3'd0;
      sa31_next = bus.a[31];
      sb31_next = bus.b[31] ^ bus.sub;
    end
  end

  assign bus.busy   = (state_reg == RUN);
  assign bus.done   = (state_reg == FIN);
  assign bus.result = result_reg;
  assign bus.cout   = cout_reg;
  assign bus.ovf    = ovf_reg;
  assign bus.zero   = zero_reg;
endmodule

// File: tb/tb_dxp_serial_adder32.sv
// Bench for dxp_serial_adder32: directed table, random ops against an arithmetic model,
// and handshake / mid-operation reset sequences.
module tb_dxp_serial_adder32;
  logic clock  = 1'b0;
  logic resetn = 1'b0;

  always #5 clock = ~clock;

  dxp_serial_adder32_if bus_if ();

  dxp_serial_adder32 dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus_if)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic [31:0] res;
    logic        cout;
    logic        ovf;
    logic        zero;
  } vec_t;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] exp_hold = 32'd0;
  logic        done_at_start = 1'b0;
  vec_t        vecs [8];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h required 0x%08h", name, got, exp);
  endtask

  task automatic check1(input string name, input logic got, input logic exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %b required %b", name, got, exp);
  endtask

  // {cout, ovf, zero, result} from plain integer arithmetic
  function automatic logic [34:0] ref_op(input logic [31:0] a, input logic [31:0] b, input logic sub);
    longint sa, sb, sr;
    logic [32:0] wide;
    logic [31:0] res;
    logic        co, ov;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (sub) begin
      res = a - b;
      co  = (a >= b);
      sr  = sa - sb;
    end else begin
      wide = {1'b0, a} + {1'b0, b};
      res  = wide[31:0];
      co   = wide[32];
      sr   = sa + sb;
    end
    ov = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
    return {co, ov, (res == 32'd0), res};
  endfunction

  task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic sub);
    @(negedge clock);
    done_at_start = bus_if.done;
    bus_if.a     = a;
    bus_if.b     = b;
    bus_if.sub   = sub;
    bus_if.start = 1'b1;
    @(posedge clock);
    #1;
    bus_if.start = 1'b0;
    bus_if.a     = $urandom;
    bus_if.b     = $urandom;
    bus_if.sub   = 1'($urandom_range(0, 1));
    check1("busy_after_start", bus_if.busy, 1'b1);
  endtask

  task automatic wait_done(input string name);
    int early = 0;
    int unstable = 0;
    int idle = 0;
    for (int k = 1; k <= 7; k++) begin
      @(posedge clock);
      #1;
      if (bus_if.done) early++;
      if (!bus_if.busy) idle++;
      if (bus_if.result !== exp_hold) unstable++;
    end
    @(posedge clock);
    #1;
    check1({name, "_done_at_8"}, bus_if.done, 1'b1);
    check1({name, "_busy_low_at_done"}, bus_if.busy, 1'b0);
    check({name, "_early_done"}, 32'(early), 32'd0);
    check({name, "_busy_gaps"}, 32'(idle), 32'd0);
    check({name, "_result_unstable"}, 32'(unstable), 32'd0);
  endtask

  task automatic run_and_check(input string name, input logic [31:0] a, input logic [31:0] b,
                               input logic sub, input logic [31:0] er, input logic ec,
                               input logic eo, input logic ez);
    start_op(a, b, sub);
    wait_done(name);
    check({name, "_result"}, bus_if.result, er);
    check1({name, "_cout"}, bus_if.cout, ec);
    check1({name, "_ovf"}, bus_if.ovf, eo);
    check1({name, "_zero"}, bus_if.zero, ez);
    exp_hold = er;
    $display("op %s a=%08h b=%08h sub=%0b -> result=%08h cout=%0b ovf=%0b zero=%0b",
             name, a, b, sub, bus_if.result, bus_if.cout, bus_if.ovf, bus_if.zero);
  endtask

  initial begin
    int          dones;
    int          done_edge;
    logic [34:0] r;
    logic [31:0] ra, rb;
    logic        rs;

    vecs[0] = '{32'h0000000F, 32'h00000001, 1'b0, 32'h00000010, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1};
    vecs[2] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{32'h80000000, 32'h00000001, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0};
    vecs[4] = '{32'h00000005, 32'h00000007, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{32'h00000007, 32'h00000005, 1'b1, 32'h00000002, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{32'h12345678, 32'h12345678, 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b1};
    vecs[7] = '{32'h00000000, 32'h00000000, 1'b0, 32'h00000000, 1'b0, 1'b0, 1'b1};

    bus_if.start = 1'b0;
    bus_if.sub   = 1'b0;
    bus_if.a     = 32'd0;
    bus_if.b     = 32'd0;

    // Reset values
    resetn = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    resetn = 1'b1;
    #1;
    check1("rst_busy", bus_if.busy, 1'b0);
    check1("rst_done", bus_if.done, 1'b0);
    check("rst_result", bus_if.result, 32'd0);
    check1("rst_cout", bus_if.cout, 1'b0);
    check1("rst_ovf", bus_if.ovf, 1'b0);
    check1("rst_zero", bus_if.zero, 1'b0);
    dones = 0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clock);
      #1;
      if (bus_if.done || bus_if.busy) dones++;
    end
    check("idle_no_activity", 32'(dones), 32'd0);
    check("idle_result_held", bus_if.result, 32'd0);

    // Directed table
    for (int i = 0; i < 8; i++)
      run_and_check($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].sub,
                    vecs[i].res, vecs[i].cout, vecs[i].ovf, vecs[i].zero);

    // Random against model
    for (int i = 0; i < 40; i++) begin
      ra = $urandom;
      rb = (i % 8 == 0) ? ra : $urandom;
      rs = 1'($urandom_range(0, 1));
      if (i % 5 == 1) rb = {rb[31], 31'h7FFFFFFF};
      r = ref_op(ra, rb, rs);
      run_and_check($sformatf("rnd%0d", i), ra, rb, rs, r[31:0], r[34], r[33], r[32]);
    end

    // start while busy is ignored
    start_op(32'h11111111, 32'h22222222, 1'b0);
    dones = 0;
    done_edge = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clock);
      if (k == 3 || k == 7) begin
        bus_if.start = 1'b1;
        bus_if.a     = 32'hAAAA0000 + 32'(k);
        bus_if.b     = 32'h0000BBBB;
        bus_if.sub   = 1'b1;
      end else begin
        bus_if.start = 1'b0;
      end
      @(posedge clock);
      #1;
      if (bus_if.done) begin
        dones++;
        done_edge = k;
      end
    end
    bus_if.start = 1'b0;
    check("ignore_done_count", 32'(dones), 32'd1);
    check("ignore_done_edge", 32'(done_edge), 32'd8);
    check("ignore_result", bus_if.result, 32'h33333333);
    check1("ignore_idle_after", bus_if.busy, 1'b0);
    exp_hold = 32'h33333333;
    $display("op ignore_busy_start result=%08h dones=%0d", bus_if.result, dones);

    // Back-to-back: second start issued during the done cycle
    run_and_check("b2b_first", 32'h00000100, 32'h00000023, 1'b0, 32'h00000123, 1'b0, 1'b0, 1'b0);
    run_and_check("b2b_second", 32'h00000010, 32'h00000020, 1'b1, 32'hFFFFFFF0, 1'b0, 1'b0, 1'b0);
    check1("b2b_start_in_done_cycle", done_at_start, 1'b1);

    // Reset in cycle 4 of RUN
    start_op(32'h0F0F0F0F, 32'h01010101, 1'b0);
    repeat (3) @(posedge clock);
    @(negedge clock);
    resetn = 1'b0;
    #1;
    check1("midrst_busy", bus_if.busy, 1'b0);
    check1("midrst_done", bus_if.done, 1'b0);
    check("midrst_result", bus_if.result, 32'd0);
    @(negedge clock);
    resetn = 1'b1;
    exp_hold = 32'd0;
    dones = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clock);
      #1;
      if (bus_if.done) dones++;
    end
    check("midrst_no_done", 32'(dones), 32'd0);
    $display("op midrst aborted dones=%0d result=%08h", dones, bus_if.result);
    run_and_check("after_rst", 32'h0000FFFF, 32'h00000001, 1'b0, 32'h00010000, 1'b0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
